// File: rtl/msx_cart_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : msx_cart_bus_pkg
// Purpose  : Shared types and constants for the MSX cartridge bus front-end.
//            Holds the front-end FSM state encoding, the idle value driven
//            on td, and the widths of the internal request bus.
// Revision : 1.0 - initial release
// ============================================================================
package msx_cart_bus_pkg;

  localparam int C_TIMEOUT_W = 8;
  localparam int C_ADDR_W    = 2;
  localparam int C_DATA_W    = 8;

  // Value presented on td when no real read data is available (open bus).
  localparam logic [C_DATA_W-1:0] C_TD_IDLE = 8'hFF;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_REQ   = 3'd1,
    RD_REQ   = 3'd2,
    RD_DRIVE = 3'd3,
    RELEASE  = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/msx_cart_bus_if_if.sv
`default_nettype none
// ============================================================================
// Interface: msx_int_bus_if
// Purpose  : Internal valid/ready request bus between the cartridge
//            front-end (master) and the I/O device decoders (slave).
// Signals  : bus_valid   master->slave  request pending
//            bus_write   master->slave  1 = write, 0 = read
//            bus_address master->slave  latched cartridge address
//            bus_wdata   master->slave  latched write data
//            bus_ready   slave->master  request accepted (read data valid)
//            bus_rdata   slave->master  read data
// Revision : 1.0 - initial release
// ============================================================================
interface msx_int_bus_if;
  import msx_cart_bus_pkg::*;

  logic                bus_valid;
  logic                bus_write;
  logic [C_ADDR_W-1:0] bus_address;
  logic [C_DATA_W-1:0] bus_wdata;
  logic                bus_ready;
  logic [C_DATA_W-1:0] bus_rdata;

  modport master (
    output bus_valid, bus_write, bus_address, bus_wdata,
    input  bus_ready, bus_rdata
  );

  modport slave (
    input  bus_valid, bus_write, bus_address, bus_wdata,
    output bus_ready, bus_rdata
  );

endinterface
`default_nettype wire

// File: rtl/msx_cart_bus_if_sync.sv
`default_nettype none
// ============================================================================
// Module   : msx_cart_sync
// Purpose  : WIDTH-bit, STAGES-deep flip-flop synchroniser for signals
//            arriving asynchronously from the MSX cartridge slot. Every bit
//            resets to the matching bit of RESET_VALUE. STAGES must be >= 2.
// Ports    : clk      in  system clock
//            n_reset  in  asynchronous active-low reset
//            i_d      in  asynchronous input vector
//            o_q      out synchronised output vector
// Revision : 1.0 - initial release
// ============================================================================
module msx_cart_sync #(
  parameter int               WIDTH       = 1,
  parameter int               STAGES      = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  wire logic             clk,
  input  wire logic             n_reset,
  input  wire logic [WIDTH-1:0] i_d,
  output logic      [WIDTH-1:0] o_q
);

  // Index 0 is the first (metastability-exposed) stage.
  logic [STAGES-1:0][WIDTH-1:0] r_stage;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_stage <= {STAGES{RESET_VALUE}};
    end else begin
      r_stage <= {r_stage[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_stage[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/msx_cart_bus_if.sv
`default_nettype none
// ============================================================================
// Module   : msx_cart_bus_if
// Purpose  : MSX cartridge bus front-end. Synchronises the slot strobes,
//            turns every MSX access into exactly one valid/ready request on
//            the internal bus, stretches reads with twait until data is
//            available (or a timeout expires) and then drives td.
// Ports    : clk          in  system clock
//            n_reset      in  asynchronous active-low reset
//            n_ce         in  cartridge select, active low, async
//            n_twr        in  write strobe, active low, async
//            n_trd        in  read strobe, active low, async
//            ta[1:0]      in  address, async
//            td_in[7:0]   in  data from MSX, async
//            td_out[7:0]  out data to MSX, valid while tdir
//            tdir         out 1 = FPGA drives td
//            twait        out 1 = hold the MSX in a wait state
//            bus          --  internal request bus (master side)
// Revision : 1.0 - initial release
// ============================================================================
module msx_cart_bus_if
  import msx_cart_bus_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int WAIT_TIMEOUT = 255
) (
  input  wire logic                clk,
  input  wire logic                n_reset,
  input  wire logic                n_ce,
  input  wire logic                n_twr,
  input  wire logic                n_trd,
  input  wire logic [C_ADDR_W-1:0] ta,
  input  wire logic [C_DATA_W-1:0] td_in,
  output logic      [C_DATA_W-1:0] td_out,
  output logic                     tdir,
  output logic                     twait,
  msx_int_bus_if.master            bus
);

  // Last count value of a read wait; reaching it without bus_ready forces
  // completion with open-bus data.
  localparam logic [C_TIMEOUT_W-1:0] C_TIMEOUT_LAST = C_TIMEOUT_W'(WAIT_TIMEOUT - 1);

  localparam int C_PAYLOAD_W = C_ADDR_W + C_DATA_W;

  // --------------------------------------------------------------------------
  // Synchronisers: strobes idle high, address/data idle low.
  // --------------------------------------------------------------------------
  logic [2:0]             w_strb_sync;   // {n_ce, n_twr, n_trd}
  logic [C_PAYLOAD_W-1:0] w_data_sync;   // {ta, td_in}

  msx_cart_sync #(
    .WIDTH       (3),
    .STAGES      (SYNC_STAGES),
    .RESET_VALUE (3'b111)
  ) u_sync_strb (
    .clk     (clk),
    .n_reset (n_reset),
    .i_d     ({n_ce, n_twr, n_trd}),
    .o_q     (w_strb_sync)
  );

  msx_cart_sync #(
    .WIDTH       (C_PAYLOAD_W),
    .STAGES      (SYNC_STAGES),
    .RESET_VALUE ({C_PAYLOAD_W{1'b0}})
  ) u_sync_data (
    .clk     (clk),
    .n_reset (n_reset),
    .i_d     ({ta, td_in}),
    .o_q     (w_data_sync)
  );

  logic                w_ce_act;
  logic                w_wr_act;
  logic                w_rd_act;
  logic [C_ADDR_W-1:0] w_s_ta;
  logic [C_DATA_W-1:0] w_s_td;

  assign w_ce_act = ~w_strb_sync[2];
  assign w_wr_act = w_ce_act & ~w_strb_sync[1];
  assign w_rd_act = w_ce_act & ~w_strb_sync[0];
  assign w_s_ta   = w_data_sync[C_PAYLOAD_W-1:C_DATA_W];
  assign w_s_td   = w_data_sync[C_DATA_W-1:0];

  // --------------------------------------------------------------------------
  // FSM with registered outputs
  // --------------------------------------------------------------------------
  state_t                 r_state;
  logic [C_TIMEOUT_W-1:0] r_wait_cnt;
  logic [C_DATA_W-1:0]    r_td_out;
  logic                   r_tdir;
  logic                   r_twait;
  logic                   r_valid;
  logic                   r_write;
  logic [C_ADDR_W-1:0]    r_addr;
  logic [C_DATA_W-1:0]    r_wdata;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state    <= IDLE;
      r_wait_cnt <= '0;
      r_td_out   <= C_TD_IDLE;
      r_tdir     <= 1'b0;
      r_twait    <= 1'b0;
      r_valid    <= 1'b0;
      r_write    <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          // Both strobes low at once is not a legal MSX cycle and is ignored.
          if (w_wr_act && !w_rd_act) begin
            r_addr  <= w_s_ta;
            r_wdata <= w_s_td;
            r_valid <= 1'b1;
            r_write <= 1'b1;
            r_state <= WR_REQ;
          end else if (w_rd_act && !w_wr_act) begin
            r_addr     <= w_s_ta;
            r_valid    <= 1'b1;
            r_write    <= 1'b0;
            r_twait    <= 1'b1;
            r_wait_cnt <= '0;
            r_state    <= RD_REQ;
          end
        end

        WR_REQ: begin
          if (bus.bus_ready) begin
            r_valid <= 1'b0;
            r_state <= RELEASE;
          end
        end

        RD_REQ: begin
          if (bus.bus_ready) begin
            // Real data wins over a timeout landing in the same cycle.
            r_td_out <= bus.bus_rdata;
            r_valid  <= 1'b0;
            r_twait  <= 1'b0;
            if (w_rd_act) begin
              r_tdir  <= 1'b1;
              r_state <= RD_DRIVE;
            end else begin
              // MSX already gave up on this read: finish the handshake only.
              r_state <= IDLE;
            end
          end else if (w_rd_act) begin
            if (r_wait_cnt == C_TIMEOUT_LAST) begin
              r_td_out <= C_TD_IDLE;
              r_valid  <= 1'b0;
              r_tdir   <= 1'b1;
              r_twait  <= 1'b0;
              r_state  <= RD_DRIVE;
            end else begin
              r_wait_cnt <= r_wait_cnt + 1'b1;
            end
          end else begin
            // Strobe released mid-request: let the MSX go, keep the device
            // handshake open until it answers.
            r_twait <= 1'b0;
          end
        end

        RD_DRIVE: begin
          if (!w_rd_act) begin
            r_tdir   <= 1'b0;
            r_td_out <= C_TD_IDLE;
            r_state  <= IDLE;
          end
        end

        RELEASE: begin
          // One transaction per strobe, however long the strobe is held.
          if (!w_wr_act && !w_rd_act) begin
            r_state <= IDLE;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign td_out          = r_td_out;
  assign tdir            = r_tdir;
  assign twait           = r_twait;
  assign bus.bus_valid   = r_valid;
  assign bus.bus_write   = r_write;
  assign bus.bus_address = r_addr;
  assign bus.bus_wdata   = r_wdata;

endmodule
`default_nettype wire
